// File: rtl/wb_lsu_master.sv
`default_nettype none
// ============================================================================
// Module  : wb_lsu_master
// Purpose : Single-outstanding Wishbone pipelined load/store initiator with
//           lane steering, load extension, misalignment check and bus timeout.
// Rev     : 1.0
// ============================================================================
module wb_lsu_master #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic [1:0]  size_q, size_d, off_q, off_d;
  logic        uns_q, uns_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic        bad_req, timeout, finish, fin_err;

  function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [1:0] sz,
                                              input logic [1:0] o, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = d[{o, 3'b000} +: 8];
    h = o[1] ? d[31:16] : d[15:0];
    case (sz)
      2'd0:    r = {{24{~uns & b[7]}}, b};
      2'd1:    r = {{16{~uns & h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    size_d      = size_q;
    off_d       = off_q;
    uns_d       = uns_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    cnt_d       = cyc_q ? cnt_q + TO_W'(1) : '0;
    finish      = 1'b0;
    fin_err     = 1'b0;
    timeout     = cyc_q && (cnt_q == TO_LAST);
    bad_req     = (req_size_i == 2'd3) ||
                  (req_size_i == 2'd1 && req_addr_i[0]) ||
                  (req_size_i == 2'd2 && req_addr_i[1:0] != 2'b00);

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (bad_req) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = S_RESP;
          end else begin
            cyc_d  = 1'b1;
            stb_d  = 1'b1;
            we_d   = req_we_i;
            adr_d  = {req_addr_i[31:2], 2'b00};
            size_d = req_size_i;
            off_d  = req_addr_i[1:0];
            uns_d  = req_unsigned_i;
            cnt_d  = '0;
            case (req_size_i)
              2'd0:    sel_d = 4'b0001 << req_addr_i[1:0];
              2'd1:    sel_d = 4'b0011 << req_addr_i[1:0];
              default: sel_d = 4'b1111;
            endcase
            if (!req_we_i)              dat_d = '0;
            else if (req_size_i == 2'd0) dat_d = {4{req_wdata_i[7:0]}};
            else if (req_size_i == 2'd1) dat_d = {2{req_wdata_i[15:0]}};
            else                         dat_d = req_wdata_i;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A responder may answer in the same cycle it takes the address.
        if (!wb_stall_i && (wb_ack_i || wb_err_i)) begin
          finish  = 1'b1;
          fin_err = wb_err_i;
        end else if (timeout) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end else if (!wb_stall_i) begin
          stb_d   = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wb_ack_i || wb_err_i) begin
          finish  = 1'b1;
          fin_err = wb_err_i;
        end else if (timeout) begin
          finish  = 1'b1;
          fin_err = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (finish) begin
      cyc_d       = 1'b0;
      stb_d       = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = fin_err;
      rsp_rdata_d = (fin_err || we_q) ? '0 : load_extend(wb_dat_i, size_q, off_q, uns_q);
      state_d     = S_RESP;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      size_q      <= '0;
      off_q       <= '0;
      uns_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      size_q      <= size_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = stb_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_lsu_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_lsu_master
// Purpose : Directed + random load/store traffic against a byte-array model
//           and a configurable Wishbone responder.
// Rev     : 1.0
// ============================================================================
module tb_wb_lsu_master;
  localparam int TMO = 8;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we, req_uns;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        cyc, stb, we;
  logic [31:0] adr, dato, dati;
  logic [3:0]  sel;
  logic        stall, ack, berr;

  int n_checks, n_errors;
  int cfg_stall, cfg_mode;   // mode: 0 ack, 1 silent, 2 err, 3 err+ack
  int stall_cnt;
  logic [31:0] mem [0:255];
  logic [7:0]  ref_mem [0:1023];

  int          last_lat, last_cyc, last_stb;
  logic [31:0] last_rdata, last_adr, last_dato;
  logic [3:0]  last_sel;
  logic        last_err, last_we;

  wb_lsu_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_size_i(req_size), .req_unsigned_i(req_uns),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr),
    .wb_dat_o(dato), .wb_sel_o(sel), .wb_stall_i(stall), .wb_ack_i(ack),
    .wb_dat_i(dati), .wb_err_i(berr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int w);
    logic [31:0] x;
    x = 32'(w);
    return (x * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  assign stall = stb && (stall_cnt < cfg_stall);

  always @(posedge clk) begin
    if (rst) begin
      ack <= 1'b0; berr <= 1'b0; dati <= '0; stall_cnt <= 0;
      for (int w = 0; w < 256; w++) mem[w] <= init_word(w);
    end else begin
      ack  <= 1'b0;
      berr <= 1'b0;
      if (!cyc) stall_cnt <= 0;
      else if (stb && stall) stall_cnt <= stall_cnt + 1;
      if (cyc && stb && !stall) begin
        if (cfg_mode == 0) begin
          ack  <= 1'b1;
          dati <= mem[adr[9:2]];
          if (we) mem[adr[9:2]] <= merge(mem[adr[9:2]], dato, sel);
        end else if (cfg_mode == 2) begin
          berr <= 1'b1;
        end else if (cfg_mode == 3) begin
          ack  <= 1'b1;
          berr <= 1'b1;
          dati <= mem[adr[9:2]];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  task automatic init_ref();
    logic [31:0] w;
    for (int i = 0; i < 256; i++) begin
      w = init_word(i);
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    logic [31:0] v;
    int n;
    n = nbytes(sz);
    v = '0;
    for (int b = 0; b < n; b++) v = v | (32'(ref_mem[int'(a[9:0]) + b]) << (8*b));
    if (!u && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
    return v;
  endfunction

  // Runs one request to completion and checks everything against the model.
  task automatic xact(input logic w, input logic [31:0] a, input logic [1:0] sz,
                      input logic u, input logic [31:0] wd);
    int n, guard, exp_lat;
    bit bad, seen, stable;
    logic [31:0] exp_rd, exp_dat;
    logic [3:0]  exp_sel;
    logic        exp_err;
    n   = nbytes(sz);
    bad = (sz == 2'd3) || (int'(a[1:0]) % n != 0);
    guard = 0;
    while (!req_ready && guard < 40) begin @(posedge clk); #1; guard++; end
    check("req_ready", req_ready, 1);
    req_valid = 1; req_we = w; req_addr = a; req_size = sz; req_uns = u; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0;
    last_lat = 0; last_cyc = 0; last_stb = 0; seen = 0; stable = 1;
    last_rdata = '0; last_err = 0;
    for (int k = 1; k <= 40; k++) begin
      if (cyc) last_cyc++;
      if (stb) begin
        last_stb++;
        if (!seen) begin
          seen = 1; last_sel = sel; last_adr = adr; last_dato = dato; last_we = we;
        end else if ({sel, adr, dato, we} != {last_sel, last_adr, last_dato, last_we}) stable = 0;
      end
      if (rsp_valid) begin
        last_lat = k; last_rdata = rsp_rdata; last_err = rsp_err;
        break;
      end
      @(posedge clk); #1;
    end
    check("rsp_seen", 32'(last_lat != 0), 1);
    if (bad)                exp_lat = 1;
    else if (cfg_mode == 1) exp_lat = TMO + 1;
    else                    exp_lat = 3 + cfg_stall;
    exp_err = bad || (cfg_mode != 0);
    exp_rd  = (exp_err || w) ? 32'h0 : ref_load(a, sz, u);
    check("latency", last_lat, exp_lat);
    check("rsp_err", last_err, exp_err);
    check("rsp_rdata", last_rdata, exp_rd);
    if (bad) begin
      check("no_cyc", last_cyc, 0);
    end else begin
      exp_sel = 4'(((1 << n) - 1) << a[1:0]);
      for (int b = 0; b < 4; b++) exp_dat[8*b +: 8] = wd[8*(b % n) +: 8];
      if (!w) exp_dat = '0;
      check("cyc_cycles", last_cyc, (cfg_mode == 1) ? TMO : 2 + cfg_stall);
      check("stb_cycles", last_stb, 1 + cfg_stall);
      check("stb_stable", 32'(stable), 1);
      check("wb_adr", last_adr, {a[31:2], 2'b00});
      check("wb_sel", last_sel, exp_sel);
      check("wb_we", last_we, w);
      check("wb_dat_o", last_dato, exp_dat);
      if (!exp_err && w) for (int b = 0; b < n; b++) ref_mem[int'(a[9:0]) + b] = wd[8*b +: 8];
    end
    @(posedge clk); #1;
    check("rsp_one_cycle", rsp_valid, 0);
    check("ready_after_rsp", req_ready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r, ok;
    logic [1:0]  sz, off;
    logic [31:0] a;
    n_checks = 0; n_errors = 0;
    clk = 0; rst = 1; cfg_stall = 0; cfg_mode = 0;
    req_valid = 0; req_we = 0; req_addr = '0; req_size = '0; req_uns = 0; req_wdata = '0;
    init_ref();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("rst_ready", req_ready, 1);
    check("rst_bus", {cyc, stb, we, sel}, 0);
    check("rst_adr_dat", adr | dato, 0);
    check("rst_rsp", {rsp_valid, rsp_err}, 0);
    check("rst_rdata", rsp_rdata, 0);

    xact(1, 32'h40, 2'd2, 0, 32'hDEADBEEF);
    check("sw_sel", last_sel, 4'hF);
    check("sw_dat", last_dato, 32'hDEADBEEF);
    xact(0, 32'h40, 2'd2, 0, 32'h0);
    check("lw_data", last_rdata, 32'hDEADBEEF);
    check("lw_lat", last_lat, 3);

    xact(1, 32'h43, 2'd0, 0, 32'h80);
    check("sb_sel", last_sel, 4'b1000);
    check("sb_dat", last_dato, 32'h80808080);
    xact(0, 32'h43, 2'd0, 0, 32'h0);
    check("lb_signed", last_rdata, 32'hFFFFFF80);
    xact(0, 32'h43, 2'd0, 1, 32'h0);
    check("lbu", last_rdata, 32'h00000080);

    xact(0, 32'h41, 2'd1, 0, 32'h0);
    check("mis_err", last_err, 1);
    check("mis_lat", last_lat, 1);
    xact(0, 32'h40, 2'd3, 0, 32'h0);
    check("size3_err", last_err, 1);

    xact(1, 32'h40, 2'd2, 0, 32'h7FFF1234);
    cfg_stall = 3;
    xact(0, 32'h42, 2'd1, 0, 32'h0);
    check("stall_data", last_rdata, 32'h00007FFF);
    check("stall_sel", last_sel, 4'b1100);
    check("stall_stb", last_stb, 4);
    cfg_stall = 0;

    cfg_mode = 1;
    xact(0, 32'h40, 2'd2, 0, 32'h0);
    check("tmo_err", last_err, 1);
    check("tmo_cyc", last_cyc, TMO);
    cfg_mode = 0;
    xact(0, 32'h40, 2'd2, 0, 32'h0);
    check("post_tmo", last_rdata, 32'h7FFF1234);
    cfg_mode = 3;
    xact(0, 32'h40, 2'd2, 0, 32'h0);
    check("err_ack_err", last_err, 1);

    for (int i = 0; i < 150; i++) begin
      r  = $urandom_range(0, 9);
      sz = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      if ($urandom_range(0, 3) == 0) off = 2'($urandom_range(0, 3));
      else if (sz == 2'd0)           off = 2'($urandom_range(0, 3));
      else if (sz == 2'd1)           off = {1'($urandom_range(0, 1)), 1'b0};
      else                           off = 2'b00;
      a = {22'b0, 8'($urandom_range(0, 255)), off};
      r = $urandom_range(0, 9);
      cfg_mode  = (r < 7) ? 0 : r - 6;
      cfg_stall = $urandom_range(0, 3);
      xact(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom);
    end

    cfg_mode = 1; cfg_stall = 0;
    req_valid = 1; req_we = 0; req_addr = 32'h80; req_size = 2'd2; req_uns = 0;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_wait", {cyc, stb}, 2'b10);
    rst = 1;
    @(posedge clk); #1;
    check("rst_mid_bus", {cyc, stb}, 0);
    check("rst_mid_rsp", rsp_valid, 0);
    rst = 0;
    check("rst_mid_ready", req_ready, 1);
    ok = 1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (rsp_valid || cyc) ok = 0;
    end
    check("rst_mid_quiet", 32'(ok), 1);
    init_ref();
    cfg_mode = 0;
    xact(0, 32'h80, 2'd2, 0, 32'h0);
    check("post_rst_load", last_rdata, init_word(32));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_lsu_master.md
Name: wb_lsu_master

Overview:
Wishbone initiator that turns single load/store requests from the core's memory stage into one Wishbone classic-pipelined bus cycle. It drives the initiator side of the data port on the 3-port testbench RAM and on the FPGA data RAM. It does byte-lane steering, write-data replication, read-data extraction with sign/zero extension, misalignment detection and bus timeout. It has one transaction in flight at most.

Parameters:
TIMEOUT_CYCLES, 64, max cycles cyc_o may stay high waiting for ack/err before an error response (must be ≥2)
TO_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset; synchronous, active-high
req_valid_i  in  1  core request valid
req_ready_o  out  1  block can accept a request
req_we_i  in  1  1 = store, 0 = load
req_addr_i  in  32  byte address
req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned_i  in  1  load zero-extends when 1
req_wdata_i  in  32  store data, right-aligned
rsp_valid_o  out  1  one-cycle response strobe
rsp_rdata_o  out  32  extended load data (0 for stores and errors)
rsp_err_o  out  1  misaligned, illegal size, bus error or timeout
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_adr_o  out  32  word-aligned address {addr[31:2],2'b00}
wb_dat_o  out  32  write data
wb_sel_o  out  4  byte lane select
wb_stall_i  in  1  responder stall
wb_ack_i  in  1  responder ack
wb_dat_i  in  32  responder read data
wb_err_i  in  1  responder error

Behaviour:
- All outputs are registered. On a clock edge where wb_rst_i=1: FSM goes to IDLE. req_ready_o, which is combinational from the state, reads 1 the cycle after reset. All other outputs are 0 and the timeout counter is 0. Reset mid-transaction drops cyc/stb at that edge and no response is produced.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i: latch the request.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]≠0) or size=3: go to RESP with err=1 and rdata=0. No bus cycle is issued.
  - Otherwise go to REQ. cyc=stb=1 and we/adr/sel/dat are valid from the next cycle.
  - Stray ack/err seen while cyc=0 is ignored.
- REQ:
  - cyc=stb=1 and the address phase is held stable while wb_stall_i=1.
  - First cycle with stall=0: stb drops at the next edge and the FSM goes to WAIT.
  - If ack or err is also high in that cycle, the FSM goes directly to RESP.
- WAIT:
  - cyc=1, stb=0.
  - wb_ack_i: capture wb_dat_i, go to RESP.
  - wb_err_i: go to RESP with err=1. err takes priority over ack if both are high.
- Timeout: the counter runs while cyc=1 and clears on entering REQ. Reaching TIMEOUT_CYCLES with no ack/err gives RESP with err=1 and drops cyc.
- RESP:
  - rsp_valid_o=1 for exactly one cycle, cyc=stb=0, then IDLE.
  - There is no response backpressure. req_ready_o=0 in REQ/WAIT/RESP.
- Lane rules, with o = addr[1:0]:
  - sel: byte = 4'b0001<<o, half = 4'b0011<<o, word = 4'b1111.
  - wb_dat_o: byte = {4{wdata[7:0]}}, half = {2{wdata[15:0]}}, word = wdata. wb_dat_o is 0 on loads.
  - Loads: byte = wb_dat_i[8o+7:8o]; half = wb_dat_i[16·o[1]+15:16·o[1]].
  - Extension: sign-extend unless req_unsigned_i=1. Word is passed through.
  - Stores: rsp_rdata_o=0.
- Latency with a zero-stall responder that has a registered ack:
  - Request accepted at edge N.
  - stb high in cycle N+1.
  - ack in cycle N+2.
  - rsp_valid_o in cycle N+3.
  - Next request accepted in cycle N+4.
- Misaligned/illegal requests give rsp_valid_o in the cycle after acceptance.

Test Plan:
- Store word 0xDEADBEEF to 0x40, then load word from 0x40 → sel=F, adr=0x40, dat_o=0xDEADBEEF; load returns rdata=0xDEADBEEF, err=0, rsp_valid 3 cycles after acceptance.
- Store byte 0x80 to 0x43, then signed load byte and unsigned load byte from 0x43 → sel=4'b1000, dat_o=0x80808080; responses 0xFFFFFF80 and 0x00000080.
- Load half from 0x41 → no cyc asserted, rsp_valid next cycle, err=1, rdata=0. Also check size=3 → err=1.
- Hold wb_stall_i=1 for 3 cycles during a load half from 0x42 → stb/adr/sel=4'b1100 stable for 4 cycles. Memory word 0x7FFF1234 returns rdata=0x00007FFF.
- Responder never acks, TIMEOUT_CYCLES=8 → cyc drops, rsp_valid with err=1 after 8 cycles of cyc. Next request is accepted normally. Separately, wb_err_i together with wb_ack_i → err=1.
- Assert wb_rst_i while in WAIT → at that edge cyc=stb=0, no rsp_valid; req_ready_o=1 the cycle after reset deasserts.
